// File: rtl/vector_mem_unit.sv
// Vector load/store engine between the decode stage and a single-port word-wide data RAM.
// Moves one VLEN vector as NWORDS consecutive words to/from memory, talking to register_file.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready=1
// LD_RD   | issuing NWORDS reads, capturing the word read in the previous cycle
// LD_LAST | capturing the final read word
// LD_WB   | pulsing load with the assembled vector, done
// ST_RD   | pulsing store to request the source vector
// ST_CAP  | registering store_data
// ST_WR   | writing NWORDS words, done with the last one
module vector_mem_unit #(
  parameter int VLEN = 512,
  parameter int WORD = 32,
  parameter int AW   = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_is_store,
  input  logic [1:0]      cmd_vreg,
  input  logic [AW-1:0]   cmd_base,
  output logic            done,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_re,
  output logic            mem_we,
  output logic [WORD-1:0] mem_wdata,
  input  logic [WORD-1:0] mem_rdata,
  output logic            load,
  output logic [1:0]      load_addr_reg,
  output logic [VLEN-1:0] load_data,
  output logic            store,
  output logic [1:0]      store_addr_reg,
  input  logic [VLEN-1:0] store_data
);

  localparam int NWORDS = VLEN / WORD;
  localparam int CW     = $clog2(NWORDS);

  typedef enum logic [2:0] {
    IDLE, LD_RD, LD_LAST, LD_WB, ST_RD, ST_CAP, ST_WR
  } state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic              ready_q;
  logic [1:0]        vreg_q;
  logic [AW-1:0]     base_q;
  logic [VLEN-1:0]   ld_buf;
  logic [VLEN-1:0]   st_buf;
  logic              accept;
  logic              last_cnt;
  logic [CW-1:0]     prev_cnt;

  assign accept   = cmd_valid & ready_q;
  assign last_cnt = (cnt == CW'(NWORDS - 1));
  assign prev_cnt = cnt - 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    load      = 1'b0;
    store     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nx = cmd_is_store ? ST_RD : LD_RD;
      end
      LD_RD: begin
        mem_re   = 1'b1;
        mem_addr = base_q + AW'(cnt);
        if (last_cnt) state_nx = LD_LAST;
      end
      LD_LAST: state_nx = LD_WB;
      LD_WB: begin
        load     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      ST_RD: begin
        store    = 1'b1;
        state_nx = ST_CAP;
      end
      ST_CAP: state_nx = ST_WR;
      ST_WR: begin
        mem_we    = 1'b1;
        mem_addr  = base_q + AW'(cnt);
        mem_wdata = st_buf[cnt*WORD +: WORD];
        if (last_cnt) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: latched command, word counter and the two vector buffers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      cnt     <= '0;
      vreg_q  <= '0;
      base_q  <= '0;
      ld_buf  <= '0;
      st_buf  <= '0;
    end else begin
      ready_q <= (state_nx == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            vreg_q <= cmd_vreg;
            base_q <= cmd_base;
            cnt    <= '0;
          end
        end
        LD_RD: begin
          // Read data lags the address by one cycle, so word cnt-1 arrives now.
          if (cnt != '0) ld_buf[prev_cnt*WORD +: WORD] <= mem_rdata;
          cnt <= cnt + 1'b1;
        end
        LD_LAST: ld_buf[(NWORDS-1)*WORD +: WORD] <= mem_rdata;
        ST_CAP:  st_buf <= store_data;
        ST_WR:   cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign cmd_ready      = ready_q;
  assign load_data      = ld_buf;
  assign load_addr_reg  = vreg_q;
  assign store_addr_reg = vreg_q;

endmodule
